// File: rtl/icache_sa.sv
// icache_sa: N-way set-associative instruction cache with zero-latency lookup.
// Misses latch their set/tag/victim so the fill is immune to later pc changes.
// Replacement prefers the lowest invalid way, otherwise the per-set round-robin way.
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              rdy_from_fet,
    input  logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic              mc_ena,
    output logic [ADDR_W-1:0] addr,
    input  logic              valid_from_mc,
    input  logic [31:0]       data_from_mc
);

    localparam int OFF_W    = $clog2(LINE_WORDS);
    localparam int IDX_W    = $clog2(SETS);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_LSB = OFF_W + 2;
    localparam int TAG_LSB  = OFF_W + IDX_W + 2;
    localparam int TAG_W    = ADDR_W - TAG_LSB;

    typedef enum logic [0:0] {IDLE, FILL} state_t;

    state_t                       state_reg;
    logic                         mc_ena_reg;
    logic [ADDR_W-1:0]            addr_reg;
    logic [OFF_W-1:0]             cnt_reg;
    logic [IDX_W-1:0]             set_reg;
    logic [TAG_W-1:0]             tag_reg;
    logic [WAY_W-1:0]             victim_reg;
    logic [WAYS-1:0][SETS-1:0]    valid_reg;
    logic [SETS-1:0][WAY_W-1:0]   rr_reg;

    logic [OFF_W-1:0]             off;
    logic [IDX_W-1:0]             idx;
    logic [TAG_W-1:0]             tag_in;
    logic [WAYS-1:0]              hit_way;
    logic [WAYS-1:0][31:0]        word_way;
    logic                         hit;
    logic [WAY_W-1:0]             victim_next;
    logic [WAY_W-1:0]             rr_next;
    logic                         fill_we;
    logic                         fill_last;

    assign off    = pc[LINE_LSB-1:2];
    assign idx    = pc[TAG_LSB-1:LINE_LSB];
    assign tag_in = pc[ADDR_W-1:TAG_LSB];

    assign hit         = |hit_way;
    assign instr_valid = rdy_from_fet & hit & ~flush & (state_reg == IDLE);
    assign mc_ena      = mc_ena_reg;
    assign addr        = addr_reg;

    assign fill_we   = rdy & ~flush & (state_reg == FILL) & valid_from_mc;
    assign fill_last = fill_we & (cnt_reg == OFF_W'(LINE_WORDS - 1));
    assign rr_next   = (WAYS == 1) ? '0 : WAY_W'(victim_reg + 1'b1);

    // Per-way tag/data storage, written only by the latched victim way during a fill.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [31:0]      data_mem [SETS*LINE_WORDS];
        logic [TAG_W-1:0] tag_mem  [SETS];

        // Store the returned word; the tag is committed with the last word of the line.
        always_ff @(posedge clk) begin
            if (fill_we && victim_reg == WAY_W'(gi)) begin
                data_mem[{set_reg, cnt_reg}] <= data_from_mc;
                if (fill_last) begin
                    tag_mem[set_reg] <= tag_reg;
                end
            end
        end

        assign hit_way[gi]  = valid_reg[gi][idx] && (tag_mem[idx] == tag_in);
        assign word_way[gi] = data_mem[{idx, off}];
    end

    // Select the hitting way's word; zero when nothing hits.
    always_comb begin
        instr = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_way[w]) begin
                instr = instr | word_way[w];
            end
        end
    end

    // Victim choice: lowest-index invalid way in the set, else the round-robin pointer.
    always_comb begin
        victim_next = rr_reg[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[w][idx]) begin
                victim_next = WAY_W'(w);
            end
        end
    end

    // Control FSM: miss capture, fill sequencing, flush and replacement bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            mc_ena_reg <= 1'b0;
            addr_reg   <= '0;
            cnt_reg    <= '0;
            set_reg    <= '0;
            tag_reg    <= '0;
            victim_reg <= '0;
            valid_reg  <= '0;
            rr_reg     <= '0;
        end else if (rdy) begin
            if (flush) begin
                valid_reg  <= '0;
                rr_reg     <= '0;
                mc_ena_reg <= 1'b0;
                cnt_reg    <= '0;
                state_reg  <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rdy_from_fet && !hit) begin
                            state_reg                   <= FILL;
                            set_reg                     <= idx;
                            tag_reg                     <= tag_in;
                            victim_reg                  <= victim_next;
                            valid_reg[victim_next][idx] <= 1'b0;
                            mc_ena_reg                  <= 1'b1;
                            addr_reg                    <= {pc[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                            cnt_reg                     <= '0;
                        end
                    end
                    FILL: begin
                        if (valid_from_mc) begin
                            if (cnt_reg != OFF_W'(LINE_WORDS - 1)) begin
                                cnt_reg  <= cnt_reg + 1'b1;
                                addr_reg <= addr_reg + ADDR_W'(4);
                            end else begin
                                valid_reg[victim_reg][set_reg] <= 1'b1;
                                if (victim_reg == rr_reg[set_reg]) begin
                                    rr_reg[set_reg] <= rr_next;
                                end
                                mc_ena_reg <= 1'b0;
                                state_reg  <= IDLE;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // A line may live in at most one way of its set.
    assert property (@(posedge clk) disable iff (!rst) $onehot0(hit_way));

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed and randomized checks of icache_sa against a line-level cache model.
module tb_icache_sa;

    localparam int WAYS = 2;
    localparam int SETS = 16;
    localparam int LW   = 4;
    localparam int AW   = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          flush;
    logic          rdy_from_fet;
    logic [AW-1:0] pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          mc_ena;
    logic [AW-1:0] addr;
    logic          valid_from_mc;
    logic [31:0]   data_from_mc;

    int checks   = 0;
    int failures = 0;

    // Model: which line address sits in each (set, way), its words, and the rr pointer.
    bit          m_valid [SETS][WAYS];
    int unsigned m_line  [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][LW];
    int          m_rr    [SETS];

    icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rdy_from_fet(rdy_from_fet),
        .pc(pc), .instr_valid(instr_valid), .instr(instr), .mc_ena(mc_ena), .addr(addr),
        .valid_from_mc(valid_from_mc), .data_from_mc(data_from_mc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    function automatic bit m_lookup(input logic [AW-1:0] a, output logic [31:0] d);
        int unsigned line = int'(a) / (4 * LW);
        int unsigned s    = line % SETS;
        int unsigned o    = (int'(a) / 4) % LW;
        d = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_line[s][w] == line) begin
                d = m_data[s][w][o];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Combinational lookup of one address; no fill is started.
    task automatic probe(input logic [AW-1:0] a);
        logic [31:0] d;
        bit          h;
        pc = a;
        rdy_from_fet = 1'b1;
        #1;
        h = m_lookup(a, d);
        chk($sformatf("probe_valid@%0h", a), 32'(instr_valid), 32'(h));
        if (h) chk($sformatf("probe_instr@%0h", a), instr, d);
        rdy_from_fet = 1'b0;
        tick();
    endtask

    // Miss on a and serve the line word-by-word (base+i). Optional mid-fill events:
    // a rdy stall before word stall_at, a flush at word abort_at, an async reset at word rst_at.
    task automatic do_fill(input logic [AW-1:0] a, input logic [31:0] base, input int gap,
                           input int stall_at, input int abort_at, input int rst_at,
                           input logic [AW-1:0] alt_pc, input bit use_alt);
        int unsigned   line = int'(a) / (4 * LW);
        int unsigned   s    = line % SETS;
        int            v    = m_rr[s];
        int            g;
        logic [AW-1:0] lbase;
        logic [AW-1:0] exp_a;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        lbase = AW'(line * 4 * LW);

        pc = a;
        rdy_from_fet = 1'b1;
        #1;
        chk("miss_valid", 32'(instr_valid), 32'd0);
        chk("miss_mc_ena_low", 32'(mc_ena), 32'd0);
        tick();
        if (use_alt) begin
            pc = alt_pc;
            rdy_from_fet = 1'b1;
        end else begin
            rdy_from_fet = 1'b0;
        end
        #1;
        chk("fill_mc_ena_rise", 32'(mc_ena), 32'd1);
        chk("fill_addr0", 32'(addr), 32'(lbase));
        m_valid[s][v] = 1'b0;

        for (int i = 0; i < LW; i++) begin
            exp_a = lbase + AW'(4 * i);
            if (i == rst_at) begin
                #3;
                rst = 1'b0;
                #1;
                chk("rst_mc_ena", 32'(mc_ena), 32'd0);
                chk("rst_addr", 32'(addr), 32'd0);
                @(posedge clk);
                #2;
                rst = 1'b1;
                rdy_from_fet = 1'b0;
                m_clear();
                tick();
                return;
            end
            if (i == stall_at) begin
                rdy = 1'b0;
                valid_from_mc = 1'b1;
                data_from_mc = $urandom;
                repeat (5) begin
                    tick();
                    chk("stall_addr", 32'(addr), 32'(exp_a));
                    chk("stall_mc_ena", 32'(mc_ena), 32'd1);
                end
                rdy = 1'b1;
                valid_from_mc = 1'b0;
            end
            if (i == abort_at) begin
                flush = 1'b1;
                valid_from_mc = 1'b1;
                data_from_mc = $urandom;
                tick();
                flush = 1'b0;
                valid_from_mc = 1'b0;
                rdy_from_fet = 1'b0;
                chk("abort_mc_ena", 32'(mc_ena), 32'd0);
                m_clear();
                return;
            end
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                valid_from_mc = 1'b0;
                tick();
                chk("gap_addr", 32'(addr), 32'(exp_a));
                chk("gap_valid", 32'(instr_valid), 32'd0);
            end
            valid_from_mc = 1'b1;
            data_from_mc = base + 32'(i);
            #1;
            chk("word_addr", 32'(addr), 32'(exp_a));
            chk("word_valid", 32'(instr_valid), 32'd0);
            tick();
            valid_from_mc = 1'b0;
        end
        #1;
        chk("fill_mc_ena_fall", 32'(mc_ena), 32'd0);
        rdy_from_fet = 1'b0;

        m_valid[s][v] = 1'b1;
        m_line[s][v]  = line;
        for (int i = 0; i < LW; i++) m_data[s][v][i] = base + 32'(i);
        if (v == m_rr[s]) m_rr[s] = (v + 1) % WAYS;
    endtask

    logic [AW-1:0] rpc;
    logic [AW-1:0] ralt;
    logic [31:0]   rd;

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        rdy_from_fet = 1'b0;
        pc = '0;
        valid_from_mc = 1'b0;
        data_from_mc = '0;
        m_clear();

        // Reset state
        #12;
        chk("reset_mc_ena", 32'(mc_ena), 32'd0);
        chk("reset_addr", 32'(addr), 32'd0);
        rst = 1'b1;
        tick();
        probe(17'h100);

        // Cold miss with one-cycle gaps
        do_fill(17'h100, 32'hA0, 1, -1, -1, -1, '0, 1'b0);
        pc = 17'h108;
        rdy_from_fet = 1'b1;
        #1;
        chk("cold_hit_valid", 32'(instr_valid), 32'd1);
        chk("cold_hit_instr", instr, 32'hA2);
        rdy_from_fet = 1'b0;
        tick();

        // Flush in IDLE: no hit in the flush cycle, miss afterwards
        pc = 17'h108;
        rdy_from_fet = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_cycle_valid", 32'(instr_valid), 32'd0);
        tick();
        flush = 1'b0;
        rdy_from_fet = 1'b0;
        m_clear();
        probe(17'h108);

        // Conflict fills within set 0
        do_fill(17'h000, $urandom, 0, -1, -1, -1, '0, 1'b0);
        do_fill(17'h100, $urandom, 0, -1, -1, -1, '0, 1'b0);
        probe(17'h000);
        probe(17'h104);
        do_fill(17'h200, $urandom, 0, -1, -1, -1, '0, 1'b0);
        probe(17'h10C);
        probe(17'h000);
        do_fill(17'h300, $urandom, 0, -1, -1, -1, '0, 1'b0);
        probe(17'h204);
        probe(17'h100);
        probe(17'h308);

        // PC changes to 0x500 during the fill of 0x040
        do_fill(17'h040, $urandom, 1, -1, -1, -1, 17'h500, 1'b1);
        probe(17'h500);
        probe(17'h044);

        // Flush after two of four words, then a late memory response
        do_fill(17'h600, $urandom, 0, -1, 2, -1, '0, 1'b0);
        valid_from_mc = 1'b1;
        data_from_mc = $urandom;
        tick();
        valid_from_mc = 1'b0;
        chk("late_mc_ena", 32'(mc_ena), 32'd0);
        probe(17'h200);
        probe(17'h300);
        probe(17'h044);
        probe(17'h600);

        // rdy low for 5 cycles mid-fill with memory pulses
        do_fill(17'h700, $urandom, 0, 2, -1, -1, '0, 1'b0);
        for (int o = 0; o < LW; o++) probe(17'h700 + AW'(4 * o));

        // Asynchronous reset mid-fill
        do_fill(17'h210, $urandom, 0, -1, -1, 1, '0, 1'b0);
        probe(17'h700);
        probe(17'h210);

        // Randomized traffic over a few conflicting sets
        repeat (60) begin
            rpc = AW'(((($urandom_range(0, 4) * SETS) + ($urandom_range(0, 1) * 5)) * 4 * LW)
                      + $urandom_range(0, 4 * LW - 1));
            if ($urandom_range(0, 9) == 0) begin
                pc = rpc;
                rdy_from_fet = 1'b1;
                flush = 1'b1;
                #1;
                chk("rand_flush_valid", 32'(instr_valid), 32'd0);
                tick();
                flush = 1'b0;
                rdy_from_fet = 1'b0;
                chk("rand_flush_mc_ena", 32'(mc_ena), 32'd0);
                m_clear();
            end else if (m_lookup(rpc, rd)) begin
                probe(rpc);
            end else begin
                ralt = AW'($urandom);
                do_fill(rpc, $urandom, -1, -1, -1, -1, ralt, 1'($urandom_range(0, 1)));
                probe(rpc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
